// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: program counter, IF/ID pipeline register, branch redirect with flush,
// and the halt on the B #-1 self-branch that ends test programs.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module instruction_fetch_stage #(
  parameter int unsigned            WORD_WIDTH = `WORD_WIDTH,
  parameter logic [WORD_WIDTH-1:0]  RESET_PC   = '0,
  parameter logic [WORD_WIDTH-1:0]  HALT_WORD  = 32'hEAFF_FFFF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  freeze,
  input  logic                  branch_taken,
  input  logic [WORD_WIDTH-1:0] branch_base,
  input  logic [23:0]           branch_imm,
  output logic [WORD_WIDTH-1:0] addr,
  input  logic [WORD_WIDTH-1:0] instruction,
  output logic                  if_id_valid,
  output logic [WORD_WIDTH-1:0] if_id_instruction,
  output logic [WORD_WIDTH-1:0] if_id_pc,
  output logic                  halted,
  output logic [31:0]           fetch_count
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_e;

  localparam logic [WORD_WIDTH-1:0] PC_ONE = {{(WORD_WIDTH-1){1'b0}}, 1'b1};

  state_e                state_q, state_d;
  logic [WORD_WIDTH-1:0] pc_q, pc_d;
  logic                  valid_q, valid_d;
  logic [WORD_WIDTH-1:0] instr_q, instr_d;
  logic [WORD_WIDTH-1:0] ipc_q, ipc_d;
  logic [31:0]           count_q, count_d;

  logic [WORD_WIDTH-1:0] target_s;
  logic [WORD_WIDTH-1:0] pc_inc_s;
  logic                  redirect_s;

  assign target_s = branch_base + {{(WORD_WIDTH-24){branch_imm[23]}}, branch_imm};
  assign pc_inc_s = pc_q + PC_ONE;
  // In HALT a branch back onto the halted pc is the halt branch itself and must not flush.
  assign redirect_s = branch_taken && ((state_q == RUN) || (target_s != pc_q));

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= '0;
      ipc_q   <= '0;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      count_q <= count_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (branch_taken) begin
          state_d = RUN;
        end else if (freeze) begin
          state_d = RUN;
        end else if (instruction == HALT_WORD) begin
          state_d = HALT;
        end else begin
          state_d = RUN;
        end
      end
      HALT: begin
        if (redirect_s) begin
          state_d = RUN;
        end else begin
          state_d = HALT;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Datapath next values: pc, IF/ID register, fetch counter
  always_comb begin
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    count_d = count_q;
    if (redirect_s) begin
      pc_d    = target_s;
      valid_d = 1'b0;
      instr_d = '0;
      ipc_d   = '0;
    end else if (freeze) begin
      pc_d = pc_q;
    end else if (state_q == HALT) begin
      valid_d = 1'b0;
    end else begin
      valid_d = 1'b1;
      instr_d = instruction;
      ipc_d   = pc_inc_s;
      count_d = count_q + 32'd1;
      if (instruction == HALT_WORD) begin
        pc_d = pc_q;
      end else begin
        pc_d = pc_inc_s;
      end
    end
  end

  // Output logic
  always_comb begin
    addr              = pc_q;
    halted            = (state_q == HALT);
    if_id_valid       = valid_q;
    if_id_instruction = instr_q;
    if_id_pc          = ipc_q;
    fetch_count       = count_q;
  end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Table-driven directed bench for instruction_fetch_stage with a ROM stub returning addr as data.
module tb_instruction_fetch_stage;

  localparam logic [31:0] HALT_W = 32'hEAFF_FFFF;
  localparam logic [31:0] HALT_ADDR = 32'd46;

  logic        clk = 1'b0;
  logic        rst_n, freeze, branch_taken;
  logic [31:0] branch_base;
  logic [23:0] branch_imm;
  logic [31:0] addr, instruction, if_id_instruction, if_id_pc, fetch_count;
  logic        if_id_valid, halted;

  instruction_fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .branch_taken(branch_taken),
    .branch_base(branch_base), .branch_imm(branch_imm), .addr(addr),
    .instruction(instruction), .if_id_valid(if_id_valid),
    .if_id_instruction(if_id_instruction), .if_id_pc(if_id_pc),
    .halted(halted), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  always_comb instruction = (addr == HALT_ADDR) ? HALT_W : addr;

  typedef struct {
    logic        rst_n, frz, br;
    logic [31:0] base;
    logic [23:0] imm;
    logic [31:0] e_addr;
    logic        e_v;
    logic [31:0] e_ins, e_ipc;
    logic        e_h;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vq[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic add(input logic r, input logic f, input logic b, input logic [31:0] base,
                     input logic [23:0] imm, input logic [31:0] ea, input logic ev,
                     input logic [31:0] ei, input logic [31:0] ep, input logic eh,
                     input logic [31:0] ec);
    vec_t v;
    v.rst_n = r; v.frz = f; v.br = b; v.base = base; v.imm = imm;
    v.e_addr = ea; v.e_v = ev; v.e_ins = ei; v.e_ipc = ep; v.e_h = eh; v.e_cnt = ec;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (step %0d): got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic f, input logic b, input logic [31:0] base,
                      input logic [23:0] imm);
    @(negedge clk);
    rst_n = r; freeze = f; branch_taken = b; branch_base = base; branch_imm = imm;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_base = 32'd0; branch_imm = 24'd0;

    add(1'b0, 1'b0, 1'b0, 32'd0, 24'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    for (int a = 1; a <= 3; a++)
      add(1'b1, 1'b0, 1'b0, 32'd0, 24'd0, a, 1'b1, a - 1, a, 1'b0, a);
    // freeze at pc 3 for three cycles
    for (int k = 0; k < 3; k++)
      add(1'b1, 1'b1, 1'b0, 32'd0, 24'd0, 32'd3, 1'b1, 32'd2, 32'd3, 1'b0, 32'd3);
    for (int a = 4; a <= 38; a++)
      add(1'b1, 1'b0, 1'b0, 32'd0, 24'd0, a, 1'b1, a - 1, a, 1'b0, a);
    // branch 37 + (-9) -> 28
    add(1'b1, 1'b0, 1'b1, 32'd37, 24'hFFFFF7, 32'd28, 1'b0, 32'd0, 32'd0, 1'b0, 32'd38);
    add(1'b1, 1'b0, 1'b0, 32'd0, 24'd0, 32'd29, 1'b1, 32'd28, 32'd29, 1'b0, 32'd39);
    // same branch with freeze also high
    add(1'b1, 1'b1, 1'b1, 32'd37, 24'hFFFFF7, 32'd28, 1'b0, 32'd0, 32'd0, 1'b0, 32'd39);
    add(1'b1, 1'b0, 1'b0, 32'd0, 24'd0, 32'd29, 1'b1, 32'd28, 32'd29, 1'b0, 32'd40);
    for (int a = 30; a <= 46; a++)
      add(1'b1, 1'b0, 1'b0, 32'd0, 24'd0, a, 1'b1, a - 1, a, 1'b0, 40 + (a - 29));
    // halt word fetched at 46
    add(1'b1, 1'b0, 1'b0, 32'd0, 24'd0, 32'd46, 1'b1, HALT_W, 32'd47, 1'b1, 32'd58);
    add(1'b1, 1'b0, 1'b0, 32'd0, 24'd0, 32'd46, 1'b0, HALT_W, 32'd47, 1'b1, 32'd58);
    add(1'b1, 1'b0, 1'b1, 32'd47, 24'hFFFFFF, 32'd46, 1'b0, HALT_W, 32'd47, 1'b1, 32'd58);
    add(1'b1, 1'b0, 1'b1, 32'd0, 24'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd58);
    add(1'b1, 1'b0, 1'b0, 32'd0, 24'd0, 32'd1, 1'b1, 32'd0, 32'd1, 1'b0, 32'd59);
    // pc wrap at the top of the address space
    add(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 24'd0, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'd0, 1'b0, 32'd59);
    add(1'b1, 1'b0, 1'b0, 32'd0, 24'd0, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd0, 1'b0, 32'd60);
    add(1'b1, 1'b0, 1'b0, 32'd0, 24'd0, 32'd1, 1'b1, 32'd0, 32'd1, 1'b0, 32'd61);
    // reach pc 20 with valid IF/ID, freeze, then reset while frozen
    add(1'b1, 1'b0, 1'b1, 32'd19, 24'd0, 32'd19, 1'b0, 32'd0, 32'd0, 1'b0, 32'd61);
    add(1'b1, 1'b0, 1'b0, 32'd0, 24'd0, 32'd20, 1'b1, 32'd19, 32'd20, 1'b0, 32'd62);
    add(1'b1, 1'b1, 1'b0, 32'd0, 24'd0, 32'd20, 1'b1, 32'd19, 32'd20, 1'b0, 32'd62);
    add(1'b0, 1'b1, 1'b0, 32'd0, 24'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    add(1'b1, 1'b0, 1'b0, 32'd0, 24'd0, 32'd1, 1'b1, 32'd0, 32'd1, 1'b0, 32'd1);

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].rst_n, vq[i].frz, vq[i].br, vq[i].base, vq[i].imm);
      n_vec++;
      chk("addr", i, addr, vq[i].e_addr);
      chk("if_id_valid", i, {31'd0, if_id_valid}, {31'd0, vq[i].e_v});
      chk("if_id_instruction", i, if_id_instruction, vq[i].e_ins);
      chk("if_id_pc", i, if_id_pc, vq[i].e_ipc);
      chk("halted", i, {31'd0, halted}, {31'd0, vq[i].e_h});
      chk("fetch_count", i, fetch_count, vq[i].e_cnt);
    end

    // Hand sequence: reset while halted
    step(1'b1, 1'b0, 1'b1, 32'd45, 24'd0);
    step(1'b1, 1'b0, 1'b0, 32'd0, 24'd0);
    step(1'b1, 1'b0, 1'b0, 32'd0, 24'd0);
    n_vec++;
    chk("halt_entry", 900, {31'd0, halted}, 32'd1);
    chk("halt_count", 900, fetch_count, 32'd3);
    step(1'b0, 1'b0, 1'b0, 32'd0, 24'd0);
    n_vec++;
    chk("halt_reset_halted", 901, {31'd0, halted}, 32'd0);
    chk("halt_reset_addr", 901, addr, 32'd0);
    chk("halt_reset_count", 901, fetch_count, 32'd0);
    chk("halt_reset_valid", 901, {31'd0, if_id_valid}, 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'd0, 24'd0);
    n_vec++;
    chk("post_reset_addr", 902, addr, 32'd1);
    chk("post_reset_count", 902, fetch_count, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
